nes_oam_dma: RTL and testbench

Sprite OAM DMA engine for the NES console. It snoops the CPU bus for a write to the DMA trigger register and then drives the CPU's pause input, freezing the CPU. While the CPU is frozen, it masters the system bus and copies 256 bytes from CPU page `{P,8'hxx}` into the PPU OAM data port. It is the controlling end of the CPU's pause/bus-release handshake and sits beside the CPU in the console top level, feeding the CPU/DMA bus mux.

---
 rtl/nes_oam_dma.sv | 63 ++++++
 tb/tb_nes_oam_dma.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nes_oam_dma.sv
// nes_oam_dma: sprite OAM DMA, freezes the CPU and copies page {P,xx} to the OAM data port.
// Optional NES_OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle so the first READ lands on an even cycle.
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  input  logic        i_CPU_R_WN,
  input  logic [7:0]  i_DATA,
  output logic        o_PAUSE,
  output logic        o_BUS_EN,
  output logic [15:0] o_ADDR,
  output logic [7:0]  o_DATA,
  output logic        o_R_WN,
  output logic        o_BUSY
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nx;
  logic [7:0] page, idx, data;
  logic trig, align;
  assign trig = !i_CPU_R_WN && i_CPU_ADDR == DMA_REG_ADDR;
`ifdef NES_OAM_DMA_ODD_ALIGN_EN
  logic cyc_odd;
  always_ff @(posedge i_CLK) cyc_odd <= i_RST ? 1'b0 : ~cyc_odd;
  // cyc_odd==0 at HALT means the next cycle is odd, so pad by one
  assign align = ~cyc_odd;
`else
  assign align = 1'b0;
`endif
  always_ff @(posedge i_CLK) state <= i_RST ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (trig ? HALT : IDLE) :
               state == HALT  ? (align ? ALIGN : READ) :
               state == ALIGN ? READ :
               state == READ  ? WRITE :
               idx == 8'hFF   ? IDLE : READ;
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      page <= 8'h0;
      idx  <= 8'h0;
      data <= 8'h0;
    end else begin
      if (state == IDLE && trig) begin
        page <= i_CPU_DATA;
        idx  <= 8'h0;
      end
      if (state == READ) data <= i_DATA;
      if (state == WRITE) idx <= idx + 8'h1;
    end
  end
  always_comb begin
    o_PAUSE  = state != IDLE;
    o_BUS_EN = state == READ || state == WRITE;
    o_R_WN   = state != WRITE;
    o_ADDR   = state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : 16'h0;
    o_DATA   = state == WRITE ? data : 8'h0;
  end
  assign o_BUSY = o_PAUSE;
endmodule

// File: tb/tb_nes_oam_dma.sv
// tb_nes_oam_dma: randomized self-checking bench with a RAM model and per-transfer expectations.
module tb_nes_oam_dma;
  logic clk = 0, rst = 1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0] cpu_data = 8'h0;
  logic cpu_r_wn = 1;
  logic [7:0] rd_data;
  logic pause, bus_en, r_wn, busy;
  logic [15:0] addr;
  logic [7:0] data;
  logic [7:0] ram [0:65535];
  int cnt = 0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= rst ? 0 : cnt + 1;
  assign rd_data = ram[addr];
  nes_oam_dma dut (
    .i_CLK(clk), .i_RST(rst), .i_CPU_ADDR(cpu_addr), .i_CPU_DATA(cpu_data),
    .i_CPU_R_WN(cpu_r_wn), .i_DATA(rd_data), .o_PAUSE(pause), .o_BUS_EN(bus_en),
    .o_ADDR(addr), .o_DATA(data), .o_R_WN(r_wn), .o_BUSY(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cpu_idle();
    cpu_addr = 16'h0;
    cpu_data = 8'h0;
    cpu_r_wn = 1;
  endtask
  task automatic start(input logic [7:0] pg);
    cpu_addr = 16'h4014;
    cpu_data = pg;
    cpu_r_wn = 0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_pause"}, pause, 0);
    check({tag, "_bus_en"}, bus_en, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_r_wn"}, r_wn, 1);
  endtask
  // trigger already driven in the current cycle; returns at the negedge of the first idle cycle
  task automatic run(input logic [7:0] pg);
    int n_p = 0, nr = 0, nw = 0, exp_len = 513, halt_par, first_par = 0;
    logic [15:0] last_rd = 16'h0;
    @(posedge clk); #1 cpu_idle();
    @(negedge clk);
    check("pause_rise", pause, 1);
    check("busy_eq_pause", busy, pause);
    halt_par = cnt % 2;
`ifdef NES_OAM_DMA_ODD_ALIGN_EN
    exp_len = halt_par == 0 ? 514 : 513;
`endif
    while (pause && n_p < 700) begin
      n_p++;
      if (bus_en && r_wn) begin
        if (nr == 0) begin
          first_par = cnt % 2;
          check("first_rd_addr", addr, {pg, 8'h00});
        end
        if (addr !== {pg, nr[7:0]}) check("rd_addr", addr, {pg, nr[7:0]});
        last_rd = addr;
        nr++;
      end else if (bus_en) begin
        if (addr !== 16'h2004) check("wr_addr", addr, 16'h2004);
        check("wr_data", data, ram[{pg, nw[7:0]}]);
        nw++;
      end
      @(negedge clk);
    end
    check("pause_len", n_p, exp_len);
    check("n_reads", nr, 256);
    check("n_writes", nw, 256);
    check("last_rd_addr", last_rd, {pg, 8'hFF});
`ifdef NES_OAM_DMA_ODD_ALIGN_EN
    check("first_rd_even", first_par, 0);
`endif
    check_idle("post_xfer");
  endtask
  // issue a trigger so that the HALT cycle has the requested parity
  task automatic xfer(input logic [7:0] pg, input int hp);
    @(posedge clk); #1;
    while (cnt % 2 == hp) begin
      @(posedge clk); #1;
    end
    start(pg);
    run(pg);
  endtask
  initial begin
    int n, pc, wc;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + i] = 8'(i) ^ 8'hA5;
      ram[16'h0300 + i] = 8'(i) ^ 8'h5A;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 cpu_addr = 16'h4014; cpu_r_wn = 1;
    @(posedge clk); #1 cpu_addr = 16'h4015; cpu_r_wn = 0; cpu_data = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4016;
      cpu_addr = a; cpu_r_wn = 0; cpu_data = 8'($urandom);
    end
    @(posedge clk); #1 cpu_idle();
    pc = 0; n = 0;
    repeat (4) begin
      @(negedge clk);
      pc += (pause || bus_en) ? 1 : 0;
    end
    check("non_trigger_quiet", pc, 0);
    xfer(8'h02, 0);
    start(8'h03);
    run(8'h03);
    xfer(8'($urandom), 1);
    xfer(8'($urandom_range(32, 63)), 0);
    xfer(8'($urandom), 1);
    @(posedge clk); #1 start(8'h02);
    @(posedge clk); #1 cpu_idle();
    wc = 0;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (bus_en && !r_wn) begin
        if (wc == 64) break;
        wc++;
      end
    end
    check("reached_idx40", wc, 64);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_idle("mid_reset");
    wc = 0;
    repeat (600) begin
      @(negedge clk);
      wc += (bus_en && !r_wn && addr == 16'h2004) ? 1 : 0;
    end
    check("no_writes_after_reset", wc, 0);
    @(posedge clk); #1 rst = 1; start(8'h02);
    @(posedge clk); #1 rst = 0; cpu_idle();
    pc = 0;
    repeat (20) begin
      @(negedge clk);
      pc += pause ? 1 : 0;
    end
    check("reset_beats_trigger", pc, 0);
    xfer(8'h02, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
